// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C configuration bus arbiter.
//   arb_state_e     : arbiter FSM states
//   I2C_WORD_W      : transfer word width {slave addr, sub addr, data}
//   TIMEOUT_CYC_DEF : default END timeout in clock cycles (20 ms at 50 MHz)
//   cnt_width()     : timeout counter width, never below 20 bits
package i2c_arb_pkg;

    localparam int unsigned I2C_WORD_W      = 24;
    localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;
    localparam int unsigned MIN_CNT_W       = 20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_END,
        RELEASE,
        DONE
    } arb_state_e;

    function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
        int unsigned w;
        w = $clog2(timeout_cyc + 1);
        return (w < MIN_CNT_W) ? MIN_CNT_W : w;
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   last_i    : index of the last served requester; search starts after it
//   gnt_c_o   : one-hot grant (all zero when nothing requests)
//   valid_c_o : at least one request present
module i2c_rr_pick #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic [N_REQ-1:0]         gnt_c_o,
    output logic                     valid_c_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] idx;

    // Walk last+1, last+2, ... wrapping, and take the first active request.
    always_comb begin
        gnt_c_o   = '0;
        valid_c_o = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last_i) + k) % N_REQ);
            if (!valid_c_o && req_i[idx]) begin
                gnt_c_o[idx] = 1'b1;
                valid_c_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master engine among N_REQ requesters.
// Serialises 24-bit transfers, reports per-requester done/NACK, and aborts
// a transfer whose END never arrives (sticky oTIMEOUT).
// Optional macro I2C_ARB_RETRY_EN: retry a NACKed transfer up to MAX_RETRY
// times before reporting it.
// Ports:
//   iCLK, iRST_N          : clock, asynchronous active-low reset
//   iREQ, iREQ_DATA       : per-requester request level and 24-bit word
//   oGNT, oDONE, oNACK    : one-hot grant, completion pulse, failure flag
//   oI2C_GO, oI2C_DATA    : engine start and transfer word
//   iI2C_END, iI2C_ACK    : engine end level and ACK (0 = acknowledged)
//   oBUSY, oTIMEOUT       : not idle; sticky timeout indicator
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`ifdef I2C_ARB_RETRY_EN
    , parameter int unsigned MAX_RETRY = 3
`endif
) (
    input  logic                        iCLK,
    input  logic                        iRST_N,
    input  logic [N_REQ-1:0]            iREQ,
    input  logic [I2C_WORD_W*N_REQ-1:0] iREQ_DATA,
    output logic [N_REQ-1:0]            oGNT,
    output logic [N_REQ-1:0]            oDONE,
    output logic [N_REQ-1:0]            oNACK,
    output logic                        oI2C_GO,
    output logic [I2C_WORD_W-1:0]       oI2C_DATA,
    input  logic                        iI2C_END,
    input  logic                        iI2C_ACK,
    output logic                        oBUSY,
    output logic                        oTIMEOUT
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);
`ifdef I2C_ARB_RETRY_EN
    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`endif

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d;
    logic [N_REQ-1:0]        done_q, done_d;
    logic [N_REQ-1:0]        nack_q, nack_d;
    logic                    go_q, go_d;
    logic [I2C_WORD_W-1:0]   data_q, data_d;
    logic                    busy_q;
    logic                    tout_q, tout_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fail_q, fail_d;
    logic                    tpath_q, tpath_d;
    logic [1:0]              end_sync_q;
    logic [1:0]              ack_sync_q;
    logic                    end_prev_q;
`ifdef I2C_ARB_RETRY_EN
    logic [RTY_W-1:0]        retry_q, retry_d;
`endif

    logic                    end_s, ack_s, end_rise;
    logic [CNT_W-1:0]        cnt_inc;
    logic [N_REQ-1:0]        pick_gnt;
    logic                    pick_valid;
    logic [N_REQ-1:0]        req_eff;
    logic [I2C_WORD_W-1:0]   pick_data;
    logic [IDX_W-1:0]        win_idx;

    assign end_s    = end_sync_q[1];
    assign ack_s    = ack_sync_q[1];
    assign end_rise = end_s & ~end_prev_q;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // A requester still holding iREQ during its own oDONE cycle is not re-served.
    assign req_eff = iREQ & ~done_q;

    i2c_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i     (req_eff),
        .last_i    (last_q),
        .gnt_c_o   (pick_gnt),
        .valid_c_o (pick_valid)
    );

    // Select the winner's transfer word.
    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) pick_data = iREQ_DATA[I2C_WORD_W*i +: I2C_WORD_W];
        end
    end

    // Encode the current grant for the round-robin pointer.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) win_idx = IDX_W'(i);
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        nack_d  = '0;
        go_d    = 1'b0;
        data_d  = data_q;
        tout_d  = tout_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        tpath_d = tpath_q;
`ifdef I2C_ARB_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    data_d  = pick_data;
`ifdef I2C_ARB_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                go_d    = 1'b1;
                cnt_d   = '0;
                fail_d  = 1'b0;
                tpath_d = 1'b0;
                state_d = WAIT_END;
            end
            WAIT_END: begin
                go_d  = 1'b1;
                cnt_d = cnt_inc;
                if (end_rise) begin
                    fail_d  = ack_s;
                    state_d = RELEASE;
                end else if (cnt_inc >= CNT_W'(TIMEOUT_CYC)) begin
                    fail_d  = 1'b1;
                    tpath_d = 1'b1;
                    tout_d  = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // A hung engine never raised END, so there is nothing to re-arm.
                if (tpath_q) begin
                    state_d = DONE;
                end else if (!end_s) begin
`ifdef I2C_ARB_RETRY_EN
                    if (fail_q && (retry_q < RTY_W'(MAX_RETRY))) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                done_d  = gnt_q;
                nack_d  = fail_q ? gnt_q : '0;
                gnt_d   = '0;
                last_d  = win_idx;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; END/ACK pass through a 2-flop synchroniser.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            last_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            nack_q     <= '0;
            go_q       <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            tout_q     <= 1'b0;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            tpath_q    <= 1'b0;
            end_sync_q <= '0;
            ack_sync_q <= '0;
            end_prev_q <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            go_q       <= go_d;
            data_q     <= data_d;
            busy_q     <= (state_d != IDLE);
            tout_q     <= tout_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            tpath_q    <= tpath_d;
            end_sync_q <= {end_sync_q[0], iI2C_END};
            ack_sync_q <= {ack_sync_q[0], iI2C_ACK};
            end_prev_q <= end_s;
`ifdef I2C_ARB_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign oGNT      = gnt_q;
    assign oDONE     = done_q;
    assign oNACK     = nack_q;
    assign oI2C_GO   = go_q;
    assign oI2C_DATA = data_q;
    assign oBUSY     = busy_q;
    assign oTIMEOUT  = tout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: expected completions are queued as
// requests are driven and checked against oDONE/oNACK and GO activity.
module tb_i2c_bus_arbiter;

    localparam int N    = 2;
    localparam int TOUT = 100;
`ifdef I2C_ARB_RETRY_EN
    localparam int MRET = 3;
`endif

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  iREQ;
    logic [47:0]   iREQ_DATA;
    logic [N-1:0]  oGNT, oDONE, oNACK;
    logic          oI2C_GO;
    logic [23:0]   oI2C_DATA;
    logic          iI2C_END, iI2C_ACK;
    logic          oBUSY, oTIMEOUT;

    typedef struct {
        int          idx;
        logic [23:0] data;
        logic        nack;
        int          gos;
        int          go_len;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   go_cnt   = 0;
    int   go_len   = 0;
    logic go_prev  = 1'b0;

    int   eng_delay = 40;
    bit   eng_hang  = 1'b0;
    int   eng_nacks = 0;

    i2c_bus_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TOUT)
`ifdef I2C_ARB_RETRY_EN
        , .MAX_RETRY (MRET)
`endif
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iREQ      (iREQ),
        .iREQ_DATA (iREQ_DATA),
        .oGNT      (oGNT),
        .oDONE     (oDONE),
        .oNACK     (oNACK),
        .oI2C_GO   (oI2C_GO),
        .oI2C_DATA (oI2C_DATA),
        .iI2C_END  (iI2C_END),
        .iI2C_ACK  (iI2C_ACK),
        .oBUSY     (oBUSY),
        .oTIMEOUT  (oTIMEOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic expect_xfer(input int idx, input logic [23:0] d, input logic nack,
                               input int gos, input int glen);
        exp_t e;
        e.idx    = idx;
        e.data   = d;
        e.nack   = nack;
        e.gos    = gos;
        e.go_len = glen;
        exp_q.push_back(e);
    endtask

    // Wait for n completions; drop each finished request unless holding all.
    task automatic serve(input int n, input bit hold);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (oDONE != '0) begin
                seen++;
                if (hold) begin
                    if (seen == n) iREQ = '0;
                end else begin
                    iREQ = iREQ & ~oDONE;
                end
            end
        end
        chk("serve_count", 32'(seen), 32'(n));
    endtask

    // Engine model: END after eng_delay cycles, held until GO drops.
    initial begin
        iI2C_END = 1'b0;
        iI2C_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (oI2C_GO === 1'b1) begin
                if (eng_hang) begin
                    while (oI2C_GO === 1'b1) @(negedge clk);
                end else begin
                    repeat (eng_delay) @(negedge clk);
                    iI2C_ACK = (eng_nacks > 0);
                    if (eng_nacks > 0) eng_nacks--;
                    iI2C_END = 1'b1;
                    while (oI2C_GO === 1'b1) @(negedge clk);
                    iI2C_END = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                go_cnt  = 0;
                go_len  = 0;
                go_prev = 1'b0;
            end else begin
                if (oI2C_GO && !go_prev) begin
                    go_cnt++;
                    chk("go_gnt_onehot", 32'($onehot(oGNT)), 32'd1);
                    if (exp_q.size() > 0) begin
                        chk("go_data", 32'(oI2C_DATA), 32'(exp_q[0].data));
                        chk("go_gnt", 32'(oGNT), 32'(1) << exp_q[0].idx);
                    end
                end
                if (oI2C_GO) go_len++;
                if (!oI2C_GO && go_prev) begin
                    if (exp_q.size() > 0 && exp_q[0].go_len != 0)
                        chk("go_len", 32'(go_len), 32'(exp_q[0].go_len));
                    go_len = 0;
                end
                if (oDONE != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 32'(oDONE), 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("done_vec", 32'(oDONE), 32'(1) << e.idx);
                        chk("done_nack", 32'(oNACK), e.nack ? (32'(1) << e.idx) : 32'd0);
                        chk("done_gos", 32'(go_cnt), 32'(e.gos));
                    end
                    go_cnt = 0;
                end
                go_prev = oI2C_GO;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        iREQ      = '0;
        iREQ_DATA = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt",  32'(oGNT), 32'd0);
        chk("rst_done", 32'(oDONE), 32'd0);
        chk("rst_nack", 32'(oNACK), 32'd0);
        chk("rst_go",   32'(oI2C_GO), 32'd0);
        chk("rst_data", 32'(oI2C_DATA), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_tout", 32'(oTIMEOUT), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 0, with grant/GO latency.
        iREQ_DATA[23:0] = 24'h72_9803;
        expect_xfer(0, 24'h72_9803, 1'b0, 1, 0);
        iREQ = 2'b01;
        @(negedge clk);
        chk("t1_gnt",  32'(oGNT), 32'd1);
        chk("t1_data", 32'(oI2C_DATA), 32'h72_9803);
        chk("t1_go_early", 32'(oI2C_GO), 32'd0);
        @(negedge clk);
        chk("t1_go", 32'(oI2C_GO), 32'd1);
        serve(1, 1'b0);
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", 32'(oBUSY), 32'd0);

        // NACK from requester 1.
        iREQ_DATA[47:24] = 24'h34_1F_A5;
`ifdef I2C_ARB_RETRY_EN
        eng_nacks = 100;
        expect_xfer(1, 24'h34_1F_A5, 1'b1, 4, 0);
        iREQ = 2'b10;
        serve(1, 1'b0);
        @(negedge clk);
        eng_nacks = 2;
        expect_xfer(1, 24'h34_1F_A5, 1'b0, 3, 0);
        iREQ = 2'b10;
        serve(1, 1'b0);
`else
        eng_nacks = 1;
        expect_xfer(1, 24'h34_1F_A5, 1'b1, 1, 0);
        iREQ = 2'b10;
        serve(1, 1'b0);
`endif
        eng_nacks = 0;
        @(negedge clk);

        // Contention: last served was 1, so grants alternate 0,1,0,1.
        iREQ_DATA = {24'h94_0A55, 24'h72_1234};
        expect_xfer(0, 24'h72_1234, 1'b0, 1, 0);
        expect_xfer(1, 24'h94_0A55, 1'b0, 1, 0);
        expect_xfer(0, 24'h72_1234, 1'b0, 1, 0);
        expect_xfer(1, 24'h94_0A55, 1'b0, 1, 0);
        iREQ = 2'b11;
        serve(4, 1'b1);
        @(negedge clk);

        // Timeout: GO held TOUT+1 cycles, NACK reported, sticky flag set.
        eng_hang = 1'b1;
        iREQ_DATA[23:0] = 24'h72_00FF;
        expect_xfer(0, 24'h72_00FF, 1'b1, 1, TOUT + 1);
        iREQ = 2'b01;
        serve(1, 1'b0);
        chk("t4_timeout", 32'(oTIMEOUT), 32'd1);
        eng_hang = 1'b0;
        @(negedge clk);
        expect_xfer(1, 24'h94_0A55, 1'b0, 1, 0);
        iREQ = 2'b10;
        serve(1, 1'b0);
        chk("t4_sticky", 32'(oTIMEOUT), 32'd1);
        @(negedge clk);

        // Reset in WAIT_END: outputs clear at once, pointer returns to 0.
        eng_hang = 1'b1;
        iREQ_DATA[23:0] = 24'h72_5A5A;
        iREQ = 2'b01;
        repeat (6) @(negedge clk);
        chk("t5_go_pre", 32'(oI2C_GO), 32'd1);
        iREQ = 2'b11;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_go",   32'(oI2C_GO), 32'd0);
        chk("t5_gnt",  32'(oGNT), 32'd0);
        chk("t5_done", 32'(oDONE), 32'd0);
        chk("t5_busy", 32'(oBUSY), 32'd0);
        chk("t5_tout", 32'(oTIMEOUT), 32'd0);
        chk("t5_data", 32'(oI2C_DATA), 32'd0);
        eng_hang = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_xfer(1, 24'h94_0A55, 1'b0, 1, 0);
        expect_xfer(0, 24'h72_5A5A, 1'b0, 1, 0);
        rst_n = 1'b1;
        serve(2, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
